// File: rtl/multicycle_add_ctrl.sv
// Serial adder: one 4-bit ripple slice reused over WIDTH/4 cycles.
// Define MULTICYCLE_ADD_SUB_EN to enable subtraction through port sub.
module multicycle_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / 4;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [KW-1:0]    k;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             carry;
  logic             accept;
  logic [KW+1:0]    idx;
  logic [4:0]       slice;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign idx    = {k, 2'b00};

`ifdef MULTICYCLE_ADD_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in = b;
  assign c_in = cin;
`endif

  always_comb begin
    slice = {1'b0, ra[idx +: 4]}
          + {1'b0, rb[idx +: 4]}
          + {4'b0, carry};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (k == KLAST) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      k     <= '0;
      ra    <= a;
      rb    <= b_in;
      carry <= c_in;
    end else if (state == RUN) begin
      sum[idx +: 4] <= slice[3:0];
      carry         <= slice[4];
      k             <= k + 1'b1;
      // Last slice carry is the block carry-out
      if (k == KLAST) cout <= slice[4];
    end
  end

endmodule

// File: tb/tb_multicycle_add_ctrl.sv
// Directed bench for multicycle_add_ctrl with WIDTH=16.
// Sub tests follow MULTICYCLE_ADD_SUB_EN.
module tb_multicycle_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  int n_chk = 0;
  int n_fail = 0;

  multicycle_add_ctrl #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic ts);
    a = ta;
    b = tb_;
    cin = tc;
    sub = ts;
  endtask

  // Full operation from idle with a one-cycle start pulse
  task automatic op(input string tag, input logic [15:0] ta,
                    input logic [15:0] tb_, input logic tc,
                    input logic ts, input logic [15:0] es,
                    input logic ec);
    drive(ta, tb_, tc, ts);
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(16'hDEAD, 16'hBEEF, ~tc, ~ts);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy0"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    tick();
    chk({tag, "_done0"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    start = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    tick();

    op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    op("cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Second start during RUN is ignored
    drive(16'h0102, 16'h0304, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    tick();
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        pulses++;
        chk("ign_sum", 32'(sum), 32'h0407);
        chk("ign_cout", 32'(cout), 32'd0);
      end
      tick();
    end
    chk("ign_pulses", 32'(pulses), 32'd1);

    // Reset mid-RUN discards the operation
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_sum", 32'(sum), 32'd0);
    chk("mid_cout", 32'(cout), 32'd0);
    op("after", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0);

    // Reset wins over simultaneous start
    drive(16'h1111, 16'h1111, 1'b0, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rs_busy", 32'(busy), 32'd0);
    tick();
    chk("rs_busy2", 32'(busy), 32'd0);

    // Start held high: one op every 5 cycles
    drive(16'h8000, 16'h8000, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    chk("bb0_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("bb0_done", 32'(done), 32'd1);
    chk("bb0_sum", 32'(sum), 32'h0000);
    chk("bb0_cout", 32'(cout), 32'd1);
    drive(16'hABCD, 16'h1111, 1'b1, 1'b0);
    tick();
    chk("bb1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("bb1_done", 32'(done), 32'd1);
    chk("bb1_sum", 32'(sum), 32'hBCDF);
    chk("bb1_cout", 32'(cout), 32'd0);
    drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    tick();
    chk("bb2_busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bb2_done", 32'(done), 32'd1);
    chk("bb2_sum", 32'(sum), 32'hFFFF);
    chk("bb2_cout", 32'(cout), 32'd0);
    tick();
    chk("bb2_idle", 32'(done), 32'd0);

`ifdef MULTICYCLE_ADD_SUB_EN
    op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    op("sub_off", 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0);
`else
    op("sub_ign", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
